// File: rtl/axi_sram_slave_if.sv
// AXI bus bundle for axi_sram_slave: AR, R, AW, W and B channels.
// The slave modport is used by the SRAM. The master modport is used by whatever drives it.
interface axi_sram_slave_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// Single-outstanding AXI slave that fronts a 2^ADDR_W x 32-bit SRAM.
// It supports byte-strobed writes, INCR/FIXED bursts, and SLVERR on unsupported size or burst.
module axi_sram_slave #(
  parameter int ADDR_W = 10
) (
  input  logic            aclk,
  input  logic            areset,
  axi_sram_slave_if.slave bus
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_RD_DATA   = 2'd1;
  localparam logic [1:0] S_WR_DATA   = 2'd2;
  localparam logic [1:0] S_WR_RESP   = 2'd3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int AW    = ADDR_W + 2;
  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]   mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [3:0]    id_q, id_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    len_q, len_d;
  logic [2:0]    size_q, size_d;
  logic [1:0]    burst_q, burst_d;
  logic [3:0]    beat_q, beat_d;
  logic          err_q, err_d;
  logic          late_q, late_d;

  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rlast_q, rlast_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [3:0]    rid_q, rid_d;

  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic [3:0]    bid_q, bid_d;

  logic          arready_c, awready_c, wready_c;
  logic          ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic [AW-1:0] step;
  logic [AW-1:0] next_addr;
  logic [3:0]    beat_inc;
  logic [31:0]   ar_word;
  logic [31:0]   next_word;
  logic          mem_we;
  logic          unused_bits;

  function automatic logic is_err(input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'b010) || (burst == BURST_RSVD);
  endfunction

  // A pending read wins over a pending write, so awready is held off whenever arvalid is high.
  assign arready_c = (state_q == S_IDLE) && !areset;
  assign awready_c = (state_q == S_IDLE) && !areset && !bus.arvalid;
  assign wready_c  = (state_q == S_WR_DATA) && !areset;

  assign ar_hs = bus.arvalid && arready_c;
  assign aw_hs = bus.awvalid && awready_c;
  assign r_hs  = rvalid_q && bus.rready;
  assign w_hs  = bus.wvalid && wready_c;
  assign b_hs  = bvalid_q && bus.bready;

  // WRAP is treated as INCR. Keeping only the low AW bits makes the word index wrap naturally.
  assign step      = (burst_q == BURST_FIXED) ? '0 : (AW'(1) << size_q);
  assign next_addr = addr_q + step;
  assign beat_inc  = beat_q + 4'd1;
  assign ar_word   = mem[bus.araddr[AW-1:2]];
  assign next_word = mem[next_addr[AW-1:2]];
  assign mem_we    = w_hs && !err_q;

  assign unused_bits = ^{bus.araddr[31:AW], bus.awaddr[31:AW], bus.wid};

  assign bus.arready = arready_c;
  assign bus.awready = awready_c;
  assign bus.wready  = wready_c;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rlast   = rlast_q;
  assign bus.rresp   = rresp_q;
  assign bus.rid     = rid_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.bid     = bid_q;

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    beat_d   = beat_q;
    err_d    = err_q;
    late_d   = late_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rlast_d  = rlast_q;
    rresp_d  = rresp_q;
    rid_d    = rid_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    bid_d    = bid_q;

    unique case (state_q)
      S_IDLE: begin
        if (ar_hs) begin
          state_d  = S_RD_DATA;
          id_d     = bus.arid;
          addr_d   = bus.araddr[AW-1:0];
          len_d    = bus.arlen;
          size_d   = bus.arsize;
          burst_d  = bus.arburst;
          beat_d   = '0;
          err_d    = is_err(bus.arsize, bus.arburst);
          rvalid_d = 1'b1;
          rid_d    = bus.arid;
          rlast_d  = (bus.arlen == 4'd0);
          rresp_d  = err_d ? RESP_SLVERR : RESP_OKAY;
          rdata_d  = err_d ? '0 : ar_word;
        end else if (aw_hs) begin
          state_d  = S_WR_DATA;
          id_d     = bus.awid;
          addr_d   = bus.awaddr[AW-1:0];
          len_d    = bus.awlen;
          size_d   = bus.awsize;
          burst_d  = bus.awburst;
          beat_d   = '0;
          err_d    = is_err(bus.awsize, bus.awburst);
          late_d   = 1'b0;
        end
      end

      S_RD_DATA: begin
        if (r_hs) begin
          if (rlast_q) begin
            state_d  = S_IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end else begin
            addr_d  = next_addr;
            beat_d  = beat_inc;
            rlast_d = (beat_inc == len_q);
            rdata_d = err_q ? '0 : next_word;
          end
        end
      end

      // late_q remembers that beats ran past awlen+1, even if the 4-bit beat count later wraps.
      S_WR_DATA: begin
        if (w_hs) begin
          addr_d = next_addr;
          beat_d = beat_inc;
          if (!bus.wlast && (beat_q == len_q)) begin
            late_d = 1'b1;
          end
          if (bus.wlast) begin
            state_d  = S_WR_RESP;
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = (err_q || late_q || (beat_q != len_q)) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end

      S_WR_RESP: begin
        if (b_hs) begin
          state_d  = S_IDLE;
          bvalid_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= S_IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
      late_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rlast_q  <= 1'b0;
      rresp_q  <= '0;
      rid_q    <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
      bid_q    <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      late_q   <= late_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rlast_q  <= rlast_d;
      rresp_q  <= rresp_d;
      rid_q    <= rid_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      bid_q    <= bid_d;
    end
  end

  // The memory array is deliberately left untouched by reset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) begin
          mem[addr_q[AW-1:2]][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-index width (memory depth 2^ADDR_W 32-bit words).
REQ-002 SHALL have port aclk  input  1  the single clock; all logic is rising-edge.
REQ-003 SHALL have port areset  input  1  reset; synchronous, active-high.
REQ-004 SHALL have AR ports: arid in 4, araddr in 32, arlen in 4, arsize in 3, arburst in 2, arvalid in 1, arready out 1.
REQ-005 SHALL have R ports: rid out 4, rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1.
REQ-006 SHALL have AW ports: awid in 4, awaddr in 32, awlen in 4, awsize in 3, awburst in 2, awvalid in 1, awready out 1.
REQ-007 SHALL have W ports: wid in 4, wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1.
REQ-008 SHALL have B ports: bid out 4, bresp out 2, bvalid out 1, bready in 1.
REQ-009 SHALL ignore arlock/arcache/arprot and aw equivalents (not ported).

Function
REQ-010 SHALL implement a state machine with states IDLE, RD_DATA, WR_DATA, WR_RESP; one transaction outstanding at a time.
REQ-011 SHALL drive arready=1 and awready=1 only in IDLE, both 0 elsewhere.
REQ-012 SHALL, in IDLE with arvalid and awvalid both high, accept only the read (awready=0 that cycle).
REQ-013 SHALL, on AR handshake, latch id/addr/len/size/burst and enter RD_DATA next cycle with rvalid=1 and rdata=mem[araddr[ADDR_W+1:2]] (first-beat latency 1 cycle).
REQ-014 SHALL hold rvalid/rdata/rlast/rresp/rid stable while rvalid=1 and rready=0.
REQ-015 SHALL, on R handshake of a non-last beat, present the next beat the following cycle (one beat per cycle when rready held high).
REQ-016 SHALL assert rlast on beat index == latched arlen; R handshake with rlast returns to IDLE.
REQ-017 SHALL compute next address: burst 2'b01 (INCR) adds (1<<size) to byte address; 2'b00 (FIXED) keeps address constant; 2'b10 (WRAP) treated as INCR.
REQ-018 SHALL wrap word index modulo 2^ADDR_W (upper address bits ignored).
REQ-019 SHALL flag a transaction as error when size > 3'b010 or burst == 2'b11; error reads return rdata=0, rresp=2'b10 (SLVERR) on every beat; error writes modify no memory, bresp=2'b10.
REQ-020 SHALL return rresp/bresp=2'b00 (OKAY) otherwise; rid/bid echo latched arid/awid.
REQ-021 SHALL, on AW handshake, latch id/addr/len/size/burst and enter WR_DATA with wready=1.
REQ-022 SHALL, on each W handshake, write byte lane i of mem[word index] from wdata[8i+7:8i] iff wstrb[i]=1, then advance address per REQ-017.
REQ-023 SHALL leave WR_DATA on W handshake with wlast=1, entering WR_RESP with bvalid=1 next cycle.
REQ-024 SHALL set bresp=SLVERR if the number of W beats differs from awlen+1 (wlast early or late); all beats still written if not otherwise in error.
REQ-025 SHALL hold bvalid/bresp/bid until bready; B handshake returns to IDLE, accepting a new AR/AW no earlier than the following cycle.
REQ-026 SHALL perform memory write combined with any read in the same cycle as write-first only across transactions (no same-cycle read/write conflict is possible).

Reset
REQ-027 SHALL, while areset=1 at a clock edge, force state IDLE and clear arready, awready, wready, rvalid, rlast, bvalid, rresp, bresp, rid, bid, rdata to 0 on the next cycle.
REQ-028 SHALL gate arready/awready low in any cycle areset=1.
REQ-029 SHALL abort any in-flight burst on reset with no further R or B beats; memory contents are not cleared.

Verification
REQ-030 Single read: write word 0xDEADBEEF at 0x10, then AR araddr=0x10 arlen=0 arsize=2 arid=3 -> one beat rdata=0xDEADBEEF rlast=1 rresp=0 rid=3, one cycle after AR handshake.
REQ-031 INCR read arlen=3 from 0x0 with rready toggling 1,0,1,... -> four beats from words 0..3, data held during stalls, rlast only on 4th.
REQ-032 Byte write awaddr=0x20 wstrb=4'b0010 wdata=0x0000AB00 over 0x11223344 -> readback 0x1122AB44, bresp=0.
REQ-033 Simultaneous arvalid+awvalid in IDLE -> read completes first, awready high only after rlast handshake and return to IDLE.
REQ-034 Error cases: arsize=3'b011 -> rdata=0 rresp=2'b10; awlen=1 with wlast on first beat -> bresp=2'b10.
REQ-035 areset pulse mid-burst (after beat 2 of arlen=7) -> rvalid=0 next cycle, IDLE, arready=1 after release, memory preserved.
